// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM states, data width, writeback result.
package mau_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            is_store;
    logic            exc;
  } wb_res_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: synchronous write, combinational read, synchronous clear on reset.
module dmem_array
  import mau_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // Reset wins over a same-cycle write so an abandoned operation never lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the LSQ and writeback.
// Optional macro MISALIGN_TRAP_EN: misaligned non-forwarded accesses complete with wb_exc=1.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_LAT   = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [XLEN-1:0] issue_pc,
  input  logic [XLEN-1:0] issue_addr,
  input  logic            issue_is_store,
  input  logic [XLEN-1:0] issue_st_data,
  input  logic            issue_fwd,
  input  logic [XLEN-1:0] issue_fwd_data,
  input  logic            flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_pc,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_is_store,
  output logic            wb_exc
);

  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and payload hold until that edge, and ready never depends on valid.
  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            is_store_q, is_store_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  wb_res_t         wb_q, wb_d;

  logic [AW-1:0]   issue_idx;
  logic [AW-1:0]   mem_idx;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_we;
  logic            do_access;
  logic            acc_store;
  logic            unused_addr;

  assign issue_idx   = issue_addr[AW+1:2];
  assign unused_addr = ^{issue_addr[XLEN-1:AW+2], issue_addr[1:0]};
  assign issue_ready = (state_q == IDLE) && rstn && !flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    is_store_d = is_store_q;
    sdata_d    = sdata_q;
    wb_d       = wb_q;
    mem_idx    = idx_q;
    mem_wdata  = sdata_q;
    acc_store  = is_store_q;
    do_access  = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_valid && issue_ready) begin
          idx_d      = issue_idx;
          is_store_d = issue_is_store;
          sdata_d    = issue_st_data;
          mem_idx    = issue_idx;
          mem_wdata  = issue_st_data;
          acc_store  = issue_is_store;
          wb_d       = '{pc: issue_pc, data: '0, is_store: issue_is_store, exc: 1'b0};
          if (!issue_is_store && issue_fwd) begin
            wb_d.data = issue_fwd_data;
            state_d   = RESP;
          end
`ifdef MISALIGN_TRAP_EN
          else if (issue_addr[1:0] != 2'b00) begin
            wb_d.exc = 1'b1;
            state_d  = RESP;
          end
`endif
          else if (MEM_LAT == 1) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The array is touched only on the edge that enters RESP.
    if (do_access) begin
      mem_we = acc_store;
      if (!acc_store) wb_d.data = mem_rdata;
    end
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      is_store_q <= 1'b0;
      sdata_q    <= '0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      is_store_q <= is_store_d;
      sdata_q    <= sdata_d;
      wb_q       <= wb_d;
    end
  end

  dmem_array #(.DEPTH(MEM_DEPTH), .AW(AW)) u_dmem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign wb_valid    = (state_q == RESP);
  assign wb_pc       = wb_q.pc;
  assign wb_data     = wb_q.data;
  assign wb_is_store = wb_q.is_store;
  assign wb_exc      = wb_q.exc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random ops against a word-array reference model.
module tb_mem_access_unit;

  localparam int MEM_DEPTH = 256;
  localparam int MEM_LAT   = 2;
  localparam int AW        = $clog2(MEM_DEPTH);

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] issue_pc = '0;
  logic [31:0] issue_addr = '0;
  logic        issue_is_store = 1'b0;
  logic [31:0] issue_st_data = '0;
  logic        issue_fwd = 1'b0;
  logic [31:0] issue_fwd_data = '0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_pc;
  logic [31:0] wb_data;
  logic        wb_is_store;
  logic        wb_exc;

  logic [31:0] model_mem [MEM_DEPTH];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_access_unit #(.MEM_DEPTH(MEM_DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_pc       (issue_pc),
    .issue_addr     (issue_addr),
    .issue_is_store (issue_is_store),
    .issue_st_data  (issue_st_data),
    .issue_fwd      (issue_fwd),
    .issue_fwd_data (issue_fwd_data),
    .flush          (flush),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pc          (wb_pc),
    .wb_data        (wb_data),
    .wb_is_store    (wb_is_store),
    .wb_exc         (wb_exc)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic scramble_issue();
    issue_pc       = $urandom;
    issue_addr     = $urandom;
    issue_st_data  = $urandom;
    issue_fwd_data = $urandom;
    issue_is_store = 1'($urandom_range(0, 1));
    issue_fwd      = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!issue_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_ready_before_accept", 32'(issue_ready), 32'd1);
  endtask

  // One complete operation. flush_cyc: 0 = none, k = raise flush during cycle k after accept.
  task automatic run_op(input logic [31:0] pc, input logic [31:0] addr, input logic st,
                        input logic [31:0] sd, input logic fwd, input logic [31:0] fd,
                        input int stall, input int flush_cyc);
    int          lat;
    int          idx;
    logic [31:0] e_data;
    logic        e_exc;
    idx   = int'(addr[AW+1:2]);
    e_exc = 1'b0;
    if (!st && fwd) begin
      lat    = 1;
      e_data = fd;
    end
`ifdef MISALIGN_TRAP_EN
    else if (addr[1:0] != 2'b00) begin
      lat    = 1;
      e_exc  = 1'b1;
      e_data = '0;
    end
`endif
    else begin
      lat    = MEM_LAT;
      e_data = st ? 32'd0 : model_mem[idx];
    end
    exp_q.push_back(e_data);

    @(negedge clk);
    wait_ready();
    issue_valid    = 1'b1;
    issue_pc       = pc;
    issue_addr     = addr;
    issue_is_store = st;
    issue_st_data  = sd;
    issue_fwd      = fwd;
    issue_fwd_data = fd;
    wb_ready       = 1'b0;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    scramble_issue();

    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check_eq("busy_wb_valid", 32'(wb_valid), 32'd0);
      check_eq("busy_issue_ready", 32'(issue_ready), 32'd0);
      if (flush_cyc == c) begin
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("flush_busy_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("flush_busy_issue_ready", 32'(issue_ready), 32'd1);
        void'(exp_q.pop_front());
        return;
      end
    end

    @(negedge clk);
    e_data = exp_q.pop_front();
    check_eq("resp_wb_valid", 32'(wb_valid), 32'd1);
    check_eq("resp_wb_pc", wb_pc, pc);
    check_eq("resp_wb_data", wb_data, e_data);
    check_eq("resp_wb_is_store", 32'(wb_is_store), 32'(st));
    check_eq("resp_wb_exc", 32'(wb_exc), 32'(e_exc));
    check_eq("resp_issue_ready", 32'(issue_ready), 32'd0);
    if (st && !e_exc) model_mem[idx] = sd;

    if (flush_cyc == lat) begin
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check_eq("flush_resp_wb_valid", 32'(wb_valid), 32'd0);
      return;
    end

    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_eq("stall_wb_valid", 32'(wb_valid), 32'd1);
      check_eq("stall_wb_pc", wb_pc, pc);
      check_eq("stall_wb_data", wb_data, e_data);
      check_eq("stall_wb_is_store", 32'(wb_is_store), 32'(st));
      check_eq("stall_issue_ready", 32'(issue_ready), 32'd0);
    end

    wb_ready = 1'b1;
    @(posedge clk);
    #1 wb_ready = 1'b0;
    @(negedge clk);
    check_eq("post_hs_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("post_hs_issue_ready", 32'(issue_ready), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_issue_ready", 32'(issue_ready), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_wb_pc", wb_pc, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_wb_is_store", 32'(wb_is_store), 32'd0);
    check_eq("rst_wb_exc", 32'(wb_exc), 32'd0);
    rstn = 1'b1;
    clear_model();
    @(negedge clk);
    check_eq("post_rst_issue_ready", 32'(issue_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic        st;
    logic        fw;
    int          fl;
    clear_model();
    do_reset(3);

    // store then load back, writeback timing checked inside run_op
    run_op(32'h0000_0000, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 0);
    run_op(32'h0000_0004, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    // forwarded load, then array content at 0x40 must be intact
    run_op(32'h0000_0008, 32'h40, 1'b0, 32'h0, 1'b1, 32'h1234, 0, 0);
    run_op(32'h0000_000C, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 5, 0);
    // store with fwd set is still a real store
    run_op(32'h0000_0010, 32'h44, 1'b1, 32'hA5A5_0001, 1'b1, 32'hFFFF_FFFF, 0, 0);
    run_op(32'h0000_0014, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    // flushed store never lands
    run_op(32'h0000_0018, 32'h80, 1'b1, 32'h55, 1'b0, 32'h0, 0, 1);
    run_op(32'h0000_001C, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    // store flushed in RESP has already been written
    run_op(32'h0000_0020, 32'h84, 1'b1, 32'h77, 1'b0, 32'h0, 0, MEM_LAT);
    run_op(32'h0000_0024, 32'h84, 1'b0, 32'h0, 1'b0, 32'h0, 1, 0);
    // address wrap
    run_op(32'h0000_0028, 32'h10, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 0, 0);
    run_op(32'h0000_002C, 32'h410, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    // misaligned load
    run_op(32'h0000_0030, 32'h41, 1'b0, 32'h0, 1'b0, 32'h0, 2, 0);
    run_op(32'h0000_0034, 32'h43, 1'b1, 32'h9999, 1'b0, 32'h0, 0, 0);
    run_op(32'h0000_0038, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);

    // reset in the middle of a store: nothing written, array cleared
    @(negedge clk);
    wait_ready();
    issue_valid    = 1'b1;
    issue_pc       = 32'h100;
    issue_addr     = 32'h10;
    issue_is_store = 1'b1;
    issue_st_data  = 32'h1111_2222;
    issue_fwd      = 1'b0;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    @(negedge clk);
    do_reset(1);
    run_op(32'h0000_0104, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
    run_op(32'h0000_0108, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      a[AW+1:2] = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      st = 1'($urandom_range(0, 1));
      fw = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0) ? $urandom_range(1, MEM_LAT) : 0;
      run_op($urandom, a, st, $urandom, fw, $urandom, $urandom_range(0, 3), fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_DEPTH, 256, number of 32-bit words in the data array (power of two).
REQ-002 Parameter MEM_LAT, 2, cycles from accept to response for a memory access (minimum 1).
REQ-003 clk  input  1  the single clock for the block.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 issue_valid  input  1  LSQ presents an issued load/store.
REQ-006 issue_ready  output  1  unit can accept an issue this cycle.
REQ-007 issue_pc  input  32  PC of the issued instruction.
REQ-008 issue_addr  input  32  effective byte address.
REQ-009 issue_is_store  input  1  1 store, 0 load.
REQ-010 issue_st_data  input  32  store data.
REQ-011 issue_fwd  input  1  load already satisfied by LSQ forwarding.
REQ-012 issue_fwd_data  input  32  forwarded load data.
REQ-013 flush  input  1  pipeline flush; squash in-flight operation.
REQ-014 wb_valid  output  1  result available to writeback/ROB.
REQ-015 wb_ready  input  1  writeback accepts the result.
REQ-016 wb_pc  output  32  PC of the completing instruction.
REQ-017 wb_data  output  32  load data; 0 for stores.
REQ-018 wb_is_store  output  1  completing instruction is a store.
REQ-019 wb_exc  output  1  misaligned-access exception (only under MISALIGN_TRAP_EN; else tied 0).

Function
REQ-020 States SHALL be IDLE, BUSY, RESP; issue_ready SHALL be 1 only in IDLE with rstn=1 and flush=0.
REQ-021 Accept SHALL occur on a cycle with issue_valid=1 and issue_ready=1; all issue_* fields latched that cycle.
REQ-022 Word index SHALL be issue_addr[log2(MEM_DEPTH)+1:2]; higher bits ignored (address wraps modulo MEM_DEPTH words).
REQ-023 Forwarded load (issue_fwd=1, issue_is_store=0): IDLE->RESP; wb_valid at accept+1 with wb_data=issue_fwd_data; array not read.
REQ-024 issue_fwd SHALL be ignored when issue_is_store=1.
REQ-025 Memory access: IDLE->BUSY with latency counter loaded MEM_LAT-1; if MEM_LAT=1, IDLE->RESP directly.
REQ-026 BUSY SHALL decrement counter each cycle and go to RESP when it reaches 0; wb_valid first high at accept+MEM_LAT.
REQ-027 Store SHALL write the array exactly once, on the cycle of entry to RESP; load reads the array on that same cycle (sees all earlier stores).
REQ-028 RESP SHALL hold wb_valid and all wb_* stable until wb_ready=1; then next state IDLE, wb_valid=0 next cycle.
REQ-029 Throughput: no new accept before the cycle after the wb handshake (one op in flight).
REQ-030 flush=1 in any state SHALL force IDLE next cycle, deassert wb_valid, cancel a not-yet-performed store write; flush has priority over accept and wb handshake.
REQ-031 A store already written (in RESP) SHALL NOT be undone by flush.

Reset
REQ-032 rstn=0 at a clock edge SHALL force IDLE, counter 0, wb_valid=0, wb_pc=0, wb_data=0, wb_is_store=0, wb_exc=0, and clear all array words to 0.
REQ-033 Reset mid-BUSY SHALL abandon the operation with no array write.
REQ-034 issue_ready SHALL be 0 while rstn=0 and 1 on the first cycle after release.

Configuration
REQ-035 Macro MISALIGN_TRAP_EN defined: accept with issue_addr[1:0]!=0 (non-forwarded) SHALL go IDLE->RESP, wb_exc=1, wb_data=0, no array access, wb at accept+1.
REQ-036 Macro undefined: issue_addr[1:0] ignored, wb_exc constant 0.

Structure
REQ-037 Shared package mau_pkg SHALL hold the state enum (IDLE/BUSY/RESP), XLEN=32, and the wb result struct type.
REQ-038 Data array SHALL be a sub-module dmem_array (sync write, read, sync reset clear); FSM and counter in mem_access_unit.

Verification
REQ-039 MEM_LAT=2: store 0xDEADBEEF to 0x40 at cycle 0 -> wb_valid cycle 2, wb_is_store=1, wb_data=0; later load 0x40 -> wb_data=0xDEADBEEF.
REQ-040 Forwarded load pc=0x8, fwd_data=0x1234 at cycle 0 -> wb_valid cycle 1, wb_data=0x1234, array unchanged.
REQ-041 wb_ready held 0 for 5 cycles in RESP -> wb_* stable, issue_ready=0 throughout; accept possible cycle after handshake.
REQ-042 Store 0x55 to 0x80, flush in BUSY -> no wb, subsequent load 0x80 returns 0.
REQ-043 Load from 0x400+0x10 with MEM_DEPTH=256 -> returns word stored at 0x10 (wrap).
REQ-044 MISALIGN_TRAP_EN defined, load 0x41 -> wb_exc=1 at accept+1; undefined -> returns word at 0x40.
